// File: rtl/phy_rx_defs.sv
// Shared definitions for the two-lane PHY receive path: COM symbol and FSM encodings.
package phy_rx_defs;
   localparam logic [7:0] COM_SYM = 8'hBC;

   typedef enum logic {
      LANE_SEARCH = 1'b0,
      LANE_LOCKED = 1'b1
   } lane_state_t;

   typedef enum logic [1:0] {
      LINK_IDLE   = 2'd0,
      LINK_ALIGN  = 2'd1,
      LINK_ACTIVE = 2'd2
   } link_state_t;
endpackage

// File: rtl/phy_rx_lane_lock.sv
// One lane's symbol-lock FSM: locks on a run of COM bytes, drops on a run of invalid cycles.
// state  | meaning
// SEARCH | counting consecutive valid COM bytes
// LOCKED | counting consecutive invalid cycles
module phy_rx_lane_lock
   import phy_rx_defs::*;
#(
   parameter logic [7:0] COM        = COM_SYM,
   parameter int         LOCK_COUNT = 4,
   parameter int         LOSS_COUNT = 4
) (
   input  logic       clk_4f,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       locked
);
   localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
   localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);

   lane_state_t state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         state <= LANE_SEARCH;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The counter is reused: COM run length while searching, miss run length while locked.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         LANE_SEARCH: begin
            if (valid) cnt_nxt = (data == COM) ? cnt + 4'd1 : 4'd0;
            if (cnt_nxt == LOCK_CNT) begin
               state_nxt = LANE_LOCKED;
               cnt_nxt   = '0;
            end
         end
         LANE_LOCKED: begin
            cnt_nxt = valid ? 4'd0 : cnt + 4'd1;
            if (cnt_nxt == LOSS_CNT) begin
               state_nxt = LANE_SEARCH;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = LANE_SEARCH;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb locked = (state == LANE_LOCKED);
endmodule

// File: rtl/phy_rx_lane_ctrl.sv
// Two-lane receive controller: per-lane lock, skew measurement/removal, gated payload forwarding.
// Optional error statistics counter enabled by `define PHY_RX_LANE_STATS_EN.
// state  | meaning
// IDLE   | waiting for both lanes locked
// ALIGN  | waiting for first payload byte on each lane, measuring skew
// ACTIVE | forwarding deskewed payload
module phy_rx_lane_ctrl
   import phy_rx_defs::*;
#(
   parameter logic [7:0] COM        = COM_SYM,
   parameter int         LOCK_COUNT = 4,
   parameter int         LOSS_COUNT = 4,
   parameter int         MAX_SKEW   = 3
) (
   input  logic       clk_4f,
   input  logic       reset,
   input  logic [7:0] data_8b_0,
   input  logic       valid_8b_0,
   input  logic [7:0] data_8b_1,
   input  logic       valid_8b_1,
   output logic [7:0] data_out_0,
   output logic       valid_out_0,
   output logic [7:0] data_out_1,
   output logic       valid_out_1,
   output logic [1:0] lane_lock,
   output logic       link_up
`ifdef PHY_RX_LANE_STATS_EN
   ,
   output logic [7:0] err_count
`endif
);
   localparam int               SEL_W    = $clog2(MAX_SKEW + 1);
   localparam logic [SEL_W:0]   SKEW_LIM = (SEL_W + 1)'(MAX_SKEW);

   logic [1:0]             lock;
   logic                   both_locked;
   logic [1:0]             pay;
   logic [MAX_SKEW:1][8:0] dly_0, dly_1;
   logic [MAX_SKEW:0][8:0] tap_0, tap_1;

   link_state_t      link_state, link_nxt;
   logic [1:0]       seen, seen_nxt;
   logic [SEL_W-1:0] skew_cnt, skew_nxt;
   logic [SEL_W-1:0] sel_0, sel_0_nxt, sel_1, sel_1_nxt;
   logic [SEL_W:0]   skew_now;
   logic             late;
   logic [8:0]       out_tap_0, out_tap_1;
   logic             active_nxt, vout_0_nxt, vout_1_nxt;
   logic [7:0]       dout_0_nxt, dout_1_nxt;

   phy_rx_lane_lock #(.COM(COM), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT)) u_lock_0 (
      .clk_4f(clk_4f), .reset(reset), .data(data_8b_0), .valid(valid_8b_0), .locked(lock[0])
   );
   phy_rx_lane_lock #(.COM(COM), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT)) u_lock_1 (
      .clk_4f(clk_4f), .reset(reset), .data(data_8b_1), .valid(valid_8b_1), .locked(lock[1])
   );

   assign lane_lock   = lock;
   assign both_locked = &lock;
   assign pay         = {valid_8b_1 && (data_8b_1 != COM), valid_8b_0 && (data_8b_0 != COM)};
   assign tap_0       = {dly_0, {valid_8b_0, data_8b_0}};
   assign tap_1       = {dly_1, {valid_8b_1, data_8b_1}};

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         dly_0 <= '0;
         dly_1 <= '0;
      end else begin
         dly_0[1] <= {valid_8b_0, data_8b_0};
         dly_1[1] <= {valid_8b_1, data_8b_1};
         for (int i = 2; i <= MAX_SKEW; i++) begin
            dly_0[i] <= dly_0[i-1];
            dly_1[i] <= dly_1[i-1];
         end
      end
   end

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         link_state <= LINK_IDLE;
         seen       <= '0;
         skew_cnt   <= '0;
         sel_0      <= '0;
         sel_1      <= '0;
      end else begin
         link_state <= link_nxt;
         seen       <= seen_nxt;
         skew_cnt   <= skew_nxt;
         sel_0      <= sel_0_nxt;
         sel_1      <= sel_1_nxt;
      end
   end

   // skew_now is the skew a late lane would have if it arrived this cycle.
   always_comb begin
      link_nxt  = link_state;
      seen_nxt  = seen;
      skew_nxt  = skew_cnt;
      sel_0_nxt = sel_0;
      sel_1_nxt = sel_1;
      skew_now  = {1'b0, skew_cnt} + {{SEL_W{1'b0}}, 1'b1};
      late      = seen[0] ? pay[1] : pay[0];
      case (link_state)
         LINK_IDLE: begin
            seen_nxt = '0;
            skew_nxt = '0;
            if (both_locked) link_nxt = LINK_ALIGN;
         end
         LINK_ALIGN: begin
            if (!both_locked) begin
               link_nxt = LINK_IDLE;
            end else if (seen == 2'b00) begin
               if (pay == 2'b11) begin
                  link_nxt  = LINK_ACTIVE;
                  sel_0_nxt = '0;
                  sel_1_nxt = '0;
               end else if (pay != 2'b00) begin
                  seen_nxt = pay;
                  skew_nxt = '0;
               end
            end else if (late) begin
               link_nxt  = LINK_ACTIVE;
               seen_nxt  = '0;
               sel_0_nxt = seen[0] ? skew_now[SEL_W-1:0] : '0;
               sel_1_nxt = seen[1] ? skew_now[SEL_W-1:0] : '0;
            end else if (skew_now >= SKEW_LIM) begin
               link_nxt = LINK_IDLE;
            end else begin
               skew_nxt = skew_now[SEL_W-1:0];
            end
         end
         LINK_ACTIVE: begin
            if (!both_locked) link_nxt = LINK_IDLE;
         end
         default: link_nxt = LINK_IDLE;
      endcase
   end

   // Outputs load from the selects being latched on the same edge, so ALIGN->ACTIVE has no dead slot.
   always_comb begin
      out_tap_0  = tap_0[sel_0_nxt];
      out_tap_1  = tap_1[sel_1_nxt];
      active_nxt = (link_nxt == LINK_ACTIVE);
      vout_0_nxt = active_nxt && out_tap_0[8] && (out_tap_0[7:0] != COM);
      vout_1_nxt = active_nxt && out_tap_1[8] && (out_tap_1[7:0] != COM);
      dout_0_nxt = active_nxt ? out_tap_0[7:0] : 8'h00;
      dout_1_nxt = active_nxt ? out_tap_1[7:0] : 8'h00;
   end

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         link_up     <= 1'b0;
         valid_out_0 <= 1'b0;
         valid_out_1 <= 1'b0;
         data_out_0  <= '0;
         data_out_1  <= '0;
      end else begin
         link_up     <= active_nxt;
         valid_out_0 <= vout_0_nxt;
         valid_out_1 <= vout_1_nxt;
         data_out_0  <= dout_0_nxt;
         data_out_1  <= dout_1_nxt;
      end
   end

`ifdef PHY_RX_LANE_STATS_EN
   // With both lanes still locked, ALIGN->IDLE can only be a skew overflow.
   logic err_evt;
   assign err_evt = (link_nxt == LINK_IDLE) &&
                    (((link_state == LINK_ALIGN) && both_locked) || (link_state == LINK_ACTIVE));

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset)                               err_count <= '0;
      else if (err_evt && err_count != 8'hFF) err_count <= err_count + 8'd1;
   end
`endif
endmodule
